// File: rtl/axi_lite_master_arbiter.sv
// axi_lite_master_arbiter: round-robin sharing of one AXI4-Lite master port among NUM_REQ requesters,
// with one outstanding transaction in total.
module axi_lite_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      axi_lite_aclk,
    input  logic                      axi_lite_aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_W-1:0]         axi_lite_awaddr,
    output logic                      axi_lite_awvalid,
    input  logic                      axi_lite_awready,
    output logic [DATA_W-1:0]         axi_lite_wdata,
    output logic                      axi_lite_wvalid,
    input  logic                      axi_lite_wready,
    input  logic [1:0]                axi_lite_bresp,
    input  logic                      axi_lite_bvalid,
    output logic                      axi_lite_bready,
    output logic [ADDR_W-1:0]         axi_lite_araddr,
    output logic                      axi_lite_arvalid,
    input  logic                      axi_lite_arready,
    input  logic [DATA_W-1:0]         axi_lite_rdata,
    input  logic [1:0]                axi_lite_rresp,
    input  logic                      axi_lite_rvalid,
    output logic                      axi_lite_rready
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt;
    logic [PW-1:0]     idx;
    logic              any;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    // Scan from the farthest candidate down so the nearest one after ptr overwrites last and wins.
    always_comb begin
        gnt = ptr;
        idx = '0;
        any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

    assign req_ready       = (state == IDLE && any) ? NUM_REQ'(1) << gnt : '0;
    assign axi_lite_awaddr = addr;
    assign axi_lite_araddr = addr;
    assign axi_lite_wdata  = wdata;

    always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn) begin
        if (!axi_lite_aresetn) begin
            state            <= IDLE;
            ptr              <= PW'(NUM_REQ - 1);
            addr             <= '0;
            wdata            <= '0;
            axi_lite_awvalid <= 1'b0;
            axi_lite_wvalid  <= 1'b0;
            axi_lite_arvalid <= 1'b0;
            axi_lite_bready  <= 1'b0;
            axi_lite_rready  <= 1'b0;
            rsp_valid        <= '0;
            rsp_rdata        <= '0;
            rsp_resp         <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    ptr              <= gnt;
                    addr             <= req_addr[gnt*ADDR_W +: ADDR_W];
                    wdata            <= req_wdata[gnt*DATA_W +: DATA_W];
                    axi_lite_awvalid <= req_write[gnt];
                    axi_lite_wvalid  <= req_write[gnt];
                    axi_lite_arvalid <= !req_write[gnt];
                    state            <= req_write[gnt] ? WRITE : READ;
                end
                WRITE: begin
                    if (axi_lite_awready) axi_lite_awvalid <= 1'b0;
                    if (axi_lite_wready) axi_lite_wvalid <= 1'b0;
                    if ((!axi_lite_awvalid || axi_lite_awready) && (!axi_lite_wvalid || axi_lite_wready)) begin
                        axi_lite_bready <= 1'b1;
                        state           <= WRESP;
                    end
                end
                WRESP: if (axi_lite_bvalid) begin
                    axi_lite_bready <= 1'b0;
                    rsp_resp        <= axi_lite_bresp;
                    rsp_rdata       <= '0;
                    rsp_valid       <= NUM_REQ'(1) << ptr;
                    state           <= DONE;
                end
                READ: if (axi_lite_arready) begin
                    axi_lite_arvalid <= 1'b0;
                    axi_lite_rready  <= 1'b1;
                    state            <= RDATA;
                end
                RDATA: if (axi_lite_rvalid) begin
                    axi_lite_rready <= 1'b0;
                    rsp_resp        <= axi_lite_rresp;
                    rsp_rdata       <= axi_lite_rdata;
                    rsp_valid       <= NUM_REQ'(1) << ptr;
                    state           <= DONE;
                end
                DONE: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb_axi_lite_master_arbiter: directed vectors against a delay-programmable AXI4-Lite slave model.
module tb_axi_lite_master_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, req_write = '0, rsp_valid, rsp_resp;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    axi_lite_master_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
        .axi_lite_aclk(clk), .axi_lite_aresetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .axi_lite_awaddr(awaddr), .axi_lite_awvalid(awvalid), .axi_lite_awready(awready),
        .axi_lite_wdata(wdata), .axi_lite_wvalid(wvalid), .axi_lite_wready(wready),
        .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid), .axi_lite_bready(bready),
        .axi_lite_araddr(araddr), .axi_lite_arvalid(arvalid), .axi_lite_arready(arready),
        .axi_lite_rdata(rdata), .axi_lite_rresp(rresp), .axi_lite_rvalid(rvalid), .axi_lite_rready(rready)
    );

    // Slave model: each ready rises after its valid has waited *_dly cycles; responses follow after b/r_dly.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] resp_cfg = 2'b00;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hs, w_hs, ar_hs;
    logic aw_got, w_got, ar_got;
    logic [31:0] wa, wd, ra, last_addr;
    logic [31:0] mem [0:15];

    assign awready = awvalid && aw_cnt >= aw_dly;
    assign wready  = wvalid && w_cnt >= w_dly;
    assign arready = arvalid && ar_cnt >= ar_dly;
    wire aw_fire = awvalid && awready;
    wire w_fire  = wvalid && wready;
    wire ar_fire = arvalid && arready;
    wire aw_done = aw_got || aw_fire;
    wire w_done  = w_got || w_fire;
    wire ar_done = ar_got || ar_fire;
    wire [31:0] wa_now = aw_got ? wa : awaddr;
    wire [31:0] wd_now = w_got ? wd : wdata;
    wire [31:0] ra_now = ar_got ? ra : araddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hs, w_hs, ar_hs} <= '0;
            {aw_got, w_got, ar_got, bvalid, rvalid} <= '0;
            {wa, wd, ra, last_addr, rdata} <= '0;
            {bresp, rresp} <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (wvalid && !wready) w_cnt <= w_cnt + 1;
            if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
            if (aw_fire) begin aw_cnt <= 0; aw_got <= 1'b1; wa <= awaddr; aw_hs <= aw_hs + 1; last_addr <= awaddr; end
            if (w_fire) begin w_cnt <= 0; w_got <= 1'b1; wd <= wdata; w_hs <= w_hs + 1; end
            if (ar_fire) begin ar_cnt <= 0; ar_got <= 1'b1; ra <= araddr; ar_hs <= ar_hs + 1; last_addr <= araddr; end
            if (bvalid && bready) bvalid <= 1'b0;
            else if (aw_done && w_done && !bvalid) begin
                if (b_cnt >= b_dly) begin
                    bvalid <= 1'b1; bresp <= resp_cfg; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
                    mem[wa_now[5:2]] <= wd_now;
                end else b_cnt <= b_cnt + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            else if (ar_done && !rvalid) begin
                if (r_cnt >= r_dly) begin
                    rvalid <= 1'b1; rdata <= mem[ra_now[5:2]]; rresp <= resp_cfg; r_cnt <= 0; ar_got <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    typedef struct {
        int         id;
        logic       write;
        logic [31:0] addr, wdata;
        int         aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0] resp;
        logic [31:0] exp_rdata;
        logic [1:0] exp_resp;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the grant edge (first cycle of the transaction).
    task automatic wait_grant(input string nm, input logic [1:0] exp);
        int n = 0;
        #1;
        while (req_ready == 2'b00 && n < 40) begin tick(); #1; n++; end
        chk(nm, 64'(req_ready), 64'(exp));
        tick();
    endtask

    task automatic wait_rsp(input string nm, input logic [1:0] exp, output int lat, output int hold, output int bad);
        int n = 1;
        hold = 0;
        bad = 0;
        while (rsp_valid == 2'b00 && n < 60) begin
            if (bready || rready) hold++;
            if (req_ready != 2'b00) bad++;
            tick();
            n++;
        end
        chk(nm, 64'(rsp_valid), 64'(exp));
        lat = n;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int a0, w0, r0, lat, hold, bad;
        logic [1:0] oh;
        oh = 2'b01 << v.id;
        aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly; ar_dly = v.ar_dly; r_dly = v.r_dly;
        resp_cfg = v.resp;
        a0 = aw_hs; w0 = w_hs; r0 = ar_hs;
        req_valid[v.id] = 1'b1;
        req_write[v.id] = v.write;
        req_addr[v.id*32 +: 32] = v.addr;
        req_wdata[v.id*32 +: 32] = v.wdata;
        wait_grant($sformatf("v%0d_grant", k), oh);
        req_valid[v.id] = 1'b0;
        wait_rsp($sformatf("v%0d_rsp_valid", k), oh, lat, hold, bad);
        chk($sformatf("v%0d_rdata", k), 64'(rsp_rdata), 64'(v.exp_rdata));
        chk($sformatf("v%0d_resp", k), 64'(rsp_resp), 64'(v.exp_resp));
        chk($sformatf("v%0d_latency", k), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d_aw_count", k), 64'(aw_hs - a0), v.write ? 64'd1 : 64'd0);
        chk($sformatf("v%0d_w_count", k), 64'(w_hs - w0), v.write ? 64'd1 : 64'd0);
        chk($sformatf("v%0d_ar_count", k), 64'(ar_hs - r0), v.write ? 64'd0 : 64'd1);
        chk($sformatf("v%0d_addr", k), 64'(last_addr), 64'(v.addr));
        tick();
        chk($sformatf("v%0d_rsp_pulse", k), 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int lat, hold, bad;
        vecs[0] = '{id:0, write:1, addr:32'h0, wdata:32'h5a5a_4b4b, aw_dly:0, w_dly:0, b_dly:0, ar_dly:0, r_dly:0,
                    resp:2'b00, exp_rdata:32'h0, exp_resp:2'b00, exp_lat:3};
        vecs[1] = '{id:1, write:0, addr:32'h0, wdata:32'h0, aw_dly:0, w_dly:0, b_dly:0, ar_dly:0, r_dly:0,
                    resp:2'b00, exp_rdata:32'h5a5a_4b4b, exp_resp:2'b00, exp_lat:3};
        vecs[2] = '{id:0, write:1, addr:32'h4, wdata:32'h1234_5678, aw_dly:3, w_dly:0, b_dly:0, ar_dly:0, r_dly:0,
                    resp:2'b00, exp_rdata:32'h0, exp_resp:2'b00, exp_lat:6};
        vecs[3] = '{id:1, write:1, addr:32'h8, wdata:32'hdead_beef, aw_dly:0, w_dly:3, b_dly:0, ar_dly:0, r_dly:0,
                    resp:2'b00, exp_rdata:32'h0, exp_resp:2'b00, exp_lat:6};
        vecs[4] = '{id:1, write:0, addr:32'h4, wdata:32'h0, aw_dly:0, w_dly:0, b_dly:0, ar_dly:2, r_dly:0,
                    resp:2'b00, exp_rdata:32'h1234_5678, exp_resp:2'b00, exp_lat:5};
        vecs[5] = '{id:0, write:1, addr:32'hc, wdata:32'hcafe_f00d, aw_dly:0, w_dly:0, b_dly:5, ar_dly:0, r_dly:0,
                    resp:2'b10, exp_rdata:32'h0, exp_resp:2'b10, exp_lat:8};
        vecs[6] = '{id:0, write:0, addr:32'h8, wdata:32'h0, aw_dly:0, w_dly:0, b_dly:0, ar_dly:0, r_dly:5,
                    resp:2'b10, exp_rdata:32'hdead_beef, exp_resp:2'b10, exp_lat:8};
        vecs[7] = '{id:1, write:0, addr:32'hc, wdata:32'h0, aw_dly:0, w_dly:0, b_dly:0, ar_dly:0, r_dly:0,
                    resp:2'b11, exp_rdata:32'hcafe_f00d, exp_resp:2'b11, exp_lat:3};

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_resp, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        chk("reset_regs", 64'(awaddr | wdata | araddr | rsp_rdata), 64'd0);

        // Reset while a write is stuck in the address/data phase.
        aw_dly = 10; w_dly = 10;
        req_write = 2'b01; req_addr = {32'h0, 32'h20}; req_wdata = {32'h0, 32'h77};
        req_valid = 2'b11;
        wait_grant("first_grant_req0", 2'b01);
        req_valid = 2'b00;
        tick(); tick();
        chk("write_pending", 64'({awvalid, wvalid}), 64'b11);
        #2 rst_n = 1'b0;
        #1 chk("reset_drop", 64'({awvalid, wvalid, rsp_valid, bready, arvalid}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        aw_dly = 0; w_dly = 0;
        req_write = 2'b00; req_addr = {32'h0, 32'h20};
        req_valid = 2'b11;
        wait_grant("post_reset_req0", 2'b01);
        req_valid[0] = 1'b0;
        wait_rsp("post_reset_rsp0", 2'b01, lat, hold, bad);
        chk("lost_write_rdata", 64'(rsp_rdata), 64'd0);
        wait_grant("post_reset_req1", 2'b10);
        req_valid[1] = 1'b0;
        wait_rsp("post_reset_rsp1", 2'b10, lat, hold, bad);
        chk("no_write_after_reset", 64'(aw_hs), 64'd0);
        tick();

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Both requesters held valid: grants must alternate.
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; resp_cfg = 2'b00;
        req_write = 2'b01; req_addr = {32'h4, 32'h4}; req_wdata = {32'h0, 32'h44};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("alt%0d_grant", k), k[0] ? 2'b10 : 2'b01);
            if (k == 3) req_valid = 2'b00;
            wait_rsp($sformatf("alt%0d_rsp", k), k[0] ? 2'b10 : 2'b01, lat, hold, bad);
            chk($sformatf("alt%0d_latency", k), 64'(lat), 64'd3);
            if (k[0]) chk($sformatf("alt%0d_rdata", k), 64'(rsp_rdata), 64'h44);
        end
        tick();

        // Stalled B then stalled R with SLVERR; the other requester must wait.
        b_dly = 5; r_dly = 5; resp_cfg = 2'b10;
        req_write = 2'b01; req_addr = {32'h10, 32'h10}; req_wdata = {32'h0, 32'h1};
        req_valid = 2'b01;
        wait_grant("stall_w_grant", 2'b01);
        req_valid = 2'b10;
        wait_rsp("stall_w_rsp", 2'b01, lat, hold, bad);
        chk("stall_w_resp", 64'(rsp_resp), 64'b10);
        chk("stall_w_latency", 64'(lat), 64'd8);
        chk("stall_bready_hold", 64'(hold), 64'd6);
        chk("stall_w_no_grant", 64'(bad), 64'd0);
        tick();
        chk("grant_after_done", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        wait_rsp("stall_r_rsp", 2'b10, lat, hold, bad);
        chk("stall_r_resp", 64'(rsp_resp), 64'b10);
        chk("stall_r_rdata", 64'(rsp_rdata), 64'h1);
        chk("stall_r_latency", 64'(lat), 64'd8);
        chk("stall_rready_hold", 64'(hold), 64'd6);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
